// File: rtl/vga_text_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_pkg
// Shared definitions for the text-mode character RAM writer:
//   - default screen geometry (columns / rows)
//   - control-code byte values interpreted by the writer
//   - writer FSM state type
//   - tab-stop helper
// ---------------------------------------------------------------------------
package vga_text_pkg;

    localparam int VGA_COLS_DEFAULT = 80;
    localparam int VGA_ROWS_DEFAULT = 30;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_TAB   = 8'h09;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_INIT_CLR = 2'd0,
        ST_IDLE     = 2'd1,
        ST_LINE_CLR = 2'd2
    } writer_state_t;

    // Next multiple of 8 strictly above col; one extra bit so a stop past
    // the last representable column is still visible to the caller.
    function automatic logic [7:0] next_tab_stop(input logic [6:0] col);
        logic [4:0] group;
        group = {1'b0, col[6:3]} + 5'd1;
        return {group, 3'b000};
    endfunction

endpackage

// File: rtl/vga_text_fill.sv
// ---------------------------------------------------------------------------
// vga_text_fill
// Sequential address generator for block fills of the character RAM.
// A start pulse presents start_addr on the same cycle (bypass), so the
// first fill write can be registered by the caller on the start edge;
// afterwards one consecutive address is produced per cycle until len
// addresses have been issued.
//
// Ports:
//   clk25mhz   in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   launch a fill this cycle
//   start_addr in   first address of the fill
//   len        in   number of addresses to produce (>= 1)
//   running    out  a fill launched earlier is still in progress
//   active     out  an address is being issued this cycle
//   addr       out  address issued this cycle (valid when active)
//   done       out  this cycle issues the final address
// ---------------------------------------------------------------------------
module vga_text_fill #(
    parameter int AW = 12
) (
    input  logic          clk25mhz,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   len,
    output logic          running,
    output logic          active,
    output logic [AW-1:0] addr,
    output logic          done
);

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic          running_r;
    logic [AW-1:0] addr_r;
    logic [AW:0]   remain_r;
    logic [AW:0]   remain_s;

    // Select launch values or the in-flight counters for this cycle.
    always_comb begin
        addr     = addr_r;
        remain_s = remain_r;
        if (start) begin
            addr     = start_addr;
            remain_s = len;
        end else begin
            addr     = addr_r;
            remain_s = remain_r;
        end
        active  = start || running_r;
        done    = active && (remain_s == CNT_ONE);
        running = running_r;
    end

    // Advance address and remaining count while a fill is issuing.
    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            running_r <= 1'b0;
            addr_r    <= '0;
            remain_r  <= '0;
        end else if (active) begin
            running_r <= !done;
            addr_r    <= addr + ADDR_ONE;
            remain_r  <= remain_s - CNT_ONE;
        end else begin
            running_r <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_text_writer.sv
// ---------------------------------------------------------------------------
// vga_text_writer
// Producer for the text-mode character RAM. Accepts a byte stream over
// valid/ready, maintains a cursor, writes printable bytes at the cursor and
// performs hardware line-clear / screen-clear fills with 0x20.
//
// Optional feature macro: VGA_TEXT_WRITER_TAB_EN
//   defined   : 0x09 moves the cursor to the next multiple of 8 (no write);
//               if that lands at or past COLS it acts as LF.
//   undefined : 0x09 is an ordinary printable byte.
//
// Ports:
//   clk25mhz   in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   char_valid in   input byte valid
//   char_in    in   input byte
//   char_ready out  byte can be accepted this cycle (registered)
//   wr_en      out  character RAM write strobe
//   wr_address out  write address (row*COLS+col)
//   wr_data    out  write data
//   cursor_col out  cursor column
//   cursor_row out  cursor row
//   busy       out  a fill is in progress (inverse of char_ready)
// ---------------------------------------------------------------------------
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int COLS = VGA_COLS_DEFAULT,
    parameter int ROWS = VGA_ROWS_DEFAULT,
    parameter int AW   = 12
) (
    input  logic          clk25mhz,
    input  logic          reset_n,
    input  logic          char_valid,
    input  logic [7:0]    char_in,
    output logic          char_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_address,
    output logic [7:0]    wr_data,
    output logic [6:0]    cursor_col,
    output logic [4:0]    cursor_row,
    output logic          busy
);

    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
    localparam logic [AW-1:0] COLS_A     = AW'(COLS);
    localparam logic [AW:0]   LINE_LEN   = (AW+1)'(COLS);
    localparam logic [AW:0]   SCREEN_LEN = (AW+1)'(COLS * ROWS);
    localparam logic [6:0]    LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]    LAST_ROW   = 5'(ROWS - 1);
`ifdef VGA_TEXT_WRITER_TAB_EN
    localparam logic [7:0]    TAB_LIMIT  = 8'(COLS);
`endif

    writer_state_t state_r, state_s;
    logic [6:0]    col_r, col_s;
    logic [4:0]    row_r, row_s;
    logic [AW-1:0] row_base_r, row_base_s;   // row*COLS, tracked incrementally
    logic [AW-1:0] cur_addr_r, cur_addr_s;   // row_base + col
    logic          ready_r, ready_s;
    logic          busy_r;
    logic          wr_en_r, wr_en_s;
    logic [AW-1:0] wr_addr_r, wr_addr_s;
    logic [7:0]    wr_data_r, wr_data_s;

    logic          accept_s;
    logic          newline_s;
    logic [4:0]    next_row_s;
    logic [AW-1:0] next_base_s;
    logic          char_wr_s;
    logic [AW-1:0] char_addr_s;
    logic [7:0]    char_data_s;
`ifdef VGA_TEXT_WRITER_TAB_EN
    logic [7:0]    tab_col_s;
`endif

    logic          fill_start_s;
    logic [AW-1:0] fill_base_s;
    logic [AW:0]   fill_len_s;
    logic          fill_running_s;
    logic          fill_active_s;
    logic [AW-1:0] fill_addr_s;
    logic          fill_done_s;

    vga_text_fill #(
        .AW(AW)
    ) u_fill (
        .clk25mhz  (clk25mhz),
        .reset_n   (reset_n),
        .start     (fill_start_s),
        .start_addr(fill_base_s),
        .len       (fill_len_s),
        .running   (fill_running_s),
        .active    (fill_active_s),
        .addr      (fill_addr_s),
        .done      (fill_done_s)
    );

    // Next-state, cursor update and fill launch decisions.
    always_comb begin
        accept_s     = char_valid && ready_r && (state_r == ST_IDLE);
        next_row_s   = (row_r == LAST_ROW) ? 5'd0 : (row_r + 5'd1);
        next_base_s  = (row_r == LAST_ROW) ? '0 : (row_base_r + COLS_A);
        state_s      = state_r;
        col_s        = col_r;
        row_s        = row_r;
        row_base_s   = row_base_r;
        cur_addr_s   = cur_addr_r;
        char_wr_s    = 1'b0;
        char_addr_s  = cur_addr_r;
        char_data_s  = char_in;
        fill_start_s = 1'b0;
        fill_base_s  = '0;
        fill_len_s   = LINE_LEN;
        newline_s    = 1'b0;
`ifdef VGA_TEXT_WRITER_TAB_EN
        tab_col_s    = next_tab_stop(col_r);
`endif

        case (state_r)
            ST_INIT_CLR: begin
                // Launch (or relaunch after reset) unless already issuing.
                fill_start_s = !fill_running_s;
                fill_base_s  = '0;
                fill_len_s   = SCREEN_LEN;
                if (fill_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_INIT_CLR;
                end
            end
            ST_LINE_CLR: begin
                // Reached after a wrapping printable byte: cursor is already
                // on the new row, so clear from its row base.
                fill_start_s = !fill_running_s;
                fill_base_s  = row_base_r;
                fill_len_s   = LINE_LEN;
                if (fill_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LINE_CLR;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    case (char_in)
                        CHAR_LF: begin
                            newline_s = 1'b1;
                        end
                        CHAR_CR: begin
                            col_s      = 7'd0;
                            cur_addr_s = row_base_r;
                        end
                        CHAR_BS: begin
                            if (col_r != 7'd0) begin
                                col_s       = col_r - 7'd1;
                                cur_addr_s  = cur_addr_r - ADDR_ONE;
                                char_wr_s   = 1'b1;
                                char_addr_s = cur_addr_r - ADDR_ONE;
                                char_data_s = CHAR_SPACE;
                            end else begin
                                col_s = col_r;
                            end
                        end
                        CHAR_FF: begin
                            col_s        = 7'd0;
                            row_s        = 5'd0;
                            row_base_s   = '0;
                            cur_addr_s   = '0;
                            fill_start_s = 1'b1;
                            fill_base_s  = '0;
                            fill_len_s   = SCREEN_LEN;
                            state_s      = ST_INIT_CLR;
                        end
`ifdef VGA_TEXT_WRITER_TAB_EN
                        CHAR_TAB: begin
                            if (tab_col_s >= TAB_LIMIT) begin
                                newline_s = 1'b1;
                            end else begin
                                col_s      = tab_col_s[6:0];
                                cur_addr_s = cur_addr_r + AW'(tab_col_s - {1'b0, col_r});
                            end
                        end
`endif
                        default: begin
                            char_wr_s = 1'b1;
                            if (col_r == LAST_COL) begin
                                // Character goes out now; the line clear
                                // launches from ST_LINE_CLR next cycle.
                                col_s      = 7'd0;
                                row_s      = next_row_s;
                                row_base_s = next_base_s;
                                cur_addr_s = next_base_s;
                                state_s    = ST_LINE_CLR;
                            end else begin
                                col_s      = col_r + 7'd1;
                                cur_addr_s = cur_addr_r + ADDR_ONE;
                            end
                        end
                    endcase
                    if (newline_s) begin
                        // LF has no character write, so the clear of the
                        // new row starts on the acceptance edge itself.
                        col_s        = 7'd0;
                        row_s        = next_row_s;
                        row_base_s   = next_base_s;
                        cur_addr_s   = next_base_s;
                        fill_start_s = 1'b1;
                        fill_base_s  = next_base_s;
                        fill_len_s   = LINE_LEN;
                        state_s      = ST_LINE_CLR;
                    end else begin
                        newline_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_INIT_CLR;
            end
        endcase
    end

    // Merge character and fill writes into the next RAM port values.
    always_comb begin
        wr_en_s   = char_wr_s || fill_active_s;
        wr_addr_s = char_addr_s;
        wr_data_s = char_data_s;
        if (fill_active_s) begin
            wr_addr_s = fill_addr_s;
            wr_data_s = CHAR_SPACE;
        end else begin
            wr_addr_s = char_addr_s;
            wr_data_s = char_data_s;
        end
        // Ready only once the last fill write has left the port.
        ready_s = (state_s == ST_IDLE) && !fill_active_s;
    end

    // State, cursor and registered output update.
    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_INIT_CLR;
            col_r      <= 7'd0;
            row_r      <= 5'd0;
            row_base_r <= '0;
            cur_addr_r <= '0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= 8'h00;
        end else begin
            state_r    <= state_s;
            col_r      <= col_s;
            row_r      <= row_s;
            row_base_r <= row_base_s;
            cur_addr_r <= cur_addr_s;
            ready_r    <= ready_s;
            busy_r     <= !ready_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
        end
    end

    assign char_ready = ready_r;
    assign busy       = busy_r;
    assign wr_en      = wr_en_r;
    assign wr_address = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign cursor_col = col_r;
    assign cursor_row = row_r;

endmodule

// File: tb/tb_vga_text_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_writer
// Self-checking bench for vga_text_writer. A behavioural model turns every
// accepted byte into the list of RAM writes it must cause (stamped with the
// clock edge they belong to), the resulting cursor, and the edge at which
// the writer becomes ready again. DUT outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_vga_text_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int CELLS = COLS * ROWS;
`ifdef VGA_TEXT_WRITER_TAB_EN
    localparam bit TAB_EN = 1'b1;
`else
    localparam bit TAB_EN = 1'b0;
`endif

    logic          clk25mhz = 1'b0;
    logic          reset_n;
    logic          char_valid;
    logic [7:0]    char_in;
    logic          char_ready;
    logic          wr_en;
    logic [AW-1:0] wr_address;
    logic [7:0]    wr_data;
    logic [6:0]    cursor_col;
    logic [4:0]    cursor_row;
    logic          busy;

    vga_text_writer #(
        .COLS(COLS),
        .ROWS(ROWS),
        .AW  (AW)
    ) dut (
        .clk25mhz  (clk25mhz),
        .reset_n   (reset_n),
        .char_valid(char_valid),
        .char_in   (char_in),
        .char_ready(char_ready),
        .wr_en     (wr_en),
        .wr_address(wr_address),
        .wr_data   (wr_data),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    always #20 clk25mhz = ~clk25mhz;

    typedef struct {
        int edge_no;
        int addr;
        int data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream[$];
    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    int ready_at = 1000000;
    int m_col    = 0;
    int m_row    = 0;
    int last_acc = 0;
    bit burst    = 1'b0;
    bit accepted = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic push_fill(input int first_edge, input int base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{edge_no: first_edge + i, addr: base + i, data: 32'h20});
        end
    endtask

    task automatic model_newline(input int k);
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_fill(k, m_row * COLS, COLS);
        ready_at = k + COLS;
    endtask

    // Effect of a byte accepted at edge k.
    task automatic model_byte(input logic [7:0] b, input int k);
        int tab_col;
        tab_col  = (m_col / 8 + 1) * 8;
        last_acc = k;
        if (b == 8'h0A || (TAB_EN && b == 8'h09 && tab_col >= COLS)) begin
            model_newline(k);
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back('{edge_no: k, addr: m_row * COLS + m_col, data: 32'h20});
            end
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            push_fill(k, 0, CELLS);
            ready_at = k + CELLS;
        end else if (TAB_EN && b == 8'h09) begin
            m_col = tab_col;
        end else begin
            exp_q.push_back('{edge_no: k, addr: m_row * COLS + m_col, data: int'(b)});
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                push_fill(k + 1, m_row * COLS, COLS);
                ready_at = k + 1 + COLS;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_wr;
        exp_wr = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_cnt);
        check_eq("wr_en", int'(wr_en), int'(exp_wr));
        if (exp_wr) begin
            check_eq("wr_address", int'(wr_address), exp_q[0].addr);
            check_eq("wr_data", int'(wr_data), exp_q[0].data);
            void'(exp_q.pop_front());
        end
        check_eq("char_ready", int'(char_ready), int'(edge_cnt >= ready_at));
        check_eq("busy", int'(busy), int'(edge_cnt < ready_at));
        check_eq("cursor_col", int'(cursor_col), m_col);
        check_eq("cursor_row", int'(cursor_row), m_row);
    endtask

    // One clock: acceptance decided by the model's ready, outputs checked after the edge.
    task automatic run_cycle();
        bit         acc;
        logic [7:0] b;
        acc = char_valid && (edge_cnt >= ready_at);
        b   = char_in;
        @(posedge clk25mhz);
        edge_cnt++;
        if (acc) begin
            model_byte(b, edge_cnt);
        end
        #1;
        check_outputs();
        accepted = acc;
    endtask

    task automatic apply_reset(input int cycles);
        reset_n    = 1'b0;
        char_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk25mhz);
            edge_cnt++;
            #1;
        end
        check_eq("rst_char_ready", int'(char_ready), 0);
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_wr_address", int'(wr_address), 0);
        check_eq("rst_wr_data", int'(wr_data), 0);
        check_eq("rst_cursor_col", int'(cursor_col), 0);
        check_eq("rst_cursor_row", int'(cursor_row), 0);
        check_eq("rst_busy", int'(busy), 1);
        m_col   = 0;
        m_row   = 0;
        reset_n = 1'b1;
        push_fill(edge_cnt + 1, 0, CELLS);
        ready_at = edge_cnt + 1 + CELLS;
    endtask

    task automatic wait_idle();
        int guard;
        guard      = 0;
        char_valid = 1'b0;
        while ((edge_cnt < ready_at || exp_q.size() > 0) && guard < 5000) begin
            run_cycle();
            guard++;
        end
        check_eq("idle_reached", int'(guard < 5000), 1);
    endtask

    task automatic send_stream();
        int guard;
        guard = 0;
        while (stream.size() > 0 && guard < 40000) begin
            char_valid = burst || ($urandom_range(0, 3) != 0);
            char_in    = char_valid ? stream[0] : 8'($urandom);
            run_cycle();
            if (accepted) begin
                void'(stream.pop_front());
            end
            guard++;
        end
        char_valid = 1'b0;
        check_eq("stream_drained", stream.size(), 0);
        stream.delete();
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 199);
        if (r < 10)       return 8'h0A;
        else if (r < 18)  return 8'h0D;
        else if (r < 30)  return 8'h08;
        else if (r < 40)  return 8'h09;
        else if (r == 40) return 8'h0C;
        else              return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;

        // Power-up clear of the whole screen.
        apply_reset(3);
        wait_idle();

        // Back-to-back printable bytes at full rate.
        burst = 1'b1;
        stream.push_back(8'h41);
        stream.push_back(8'h42);
        send_stream();
        burst = 1'b0;

        // Walk to the bottom-right cell, then wrap with a printable byte.
        stream.push_back(8'h0D);
        for (int i = 0; i < ROWS - 1; i++) stream.push_back(8'h0A);
        for (int i = 0; i < COLS - 1; i++) stream.push_back(8'(8'h61 + i % 26));
        stream.push_back(8'h43);
        send_stream();
        wait_idle();

        // Backspace at col 5 row 3, CR, then backspace at col 0.
        for (int i = 0; i < 3; i++) stream.push_back(8'h0A);
        for (int i = 0; i < 5; i++) stream.push_back(8'(8'h30 + i));
        stream.push_back(8'h08);
        stream.push_back(8'h0D);
        stream.push_back(8'h08);
        send_stream();
        wait_idle();

        // Tab from col 3 and from col 77.
        stream.push_back(8'h0D);
        for (int i = 0; i < 3; i++) stream.push_back(8'h54);
        stream.push_back(8'h09);
        stream.push_back(8'h0D);
        for (int i = 0; i < 77; i++) stream.push_back(8'h55);
        stream.push_back(8'h09);
        send_stream();
        wait_idle();

        // Form feed mid-screen, reset after 1000 clear writes.
        burst = 1'b1;
        stream.push_back(8'h51);
        stream.push_back(8'h0C);
        send_stream();
        burst = 1'b0;
        while (edge_cnt < last_acc + 999) run_cycle();
        apply_reset(2);
        wait_idle();

        // Randomized byte mix.
        for (int i = 0; i < 250; i++) stream.push_back(rand_byte());
        send_stream();
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Producer side of the text-mode character RAM that `vga_text` reads through `char_address`/`char_data`. It accepts a byte stream over a valid/ready handshake, interprets a small set of control codes, and maintains a cursor. It issues single-cycle writes into the character RAM, including hardware line-clear and screen-clear fills. It sits between a CPU/UART byte source and the write port of the dual-port character RAM, in the `clk25mhz` domain.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 30: rows per screen.
- `AW`, default 12: character RAM address width; COLS*ROWS ≤ 2^AW.
- `clk25mhz`  in  1  pixel/system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `char_valid`  in  1  input byte valid.
- `char_in`  in  8  input byte.
- `char_ready`  out  1  block can accept a byte this cycle (registered).
- `wr_en`  out  1  character RAM write strobe.
- `wr_address`  out  AW  write address, row*COLS+col.
- `wr_data`  out  8  write data.
- `cursor_col`  out  7  current cursor column.
- `cursor_row`  out  5  current cursor row.
- `busy`  out  1  a fill (line or screen clear) is in progress.

## Operation
- Reset values: `char_ready`=0, `wr_en`=0, `wr_address`=0, `wr_data`=0, cursor 0/0, `busy`=1.
  - State is INIT_CLR on reset.
- A byte is accepted at an edge where `char_valid` and `char_ready` are both high.
  - A byte presented while `char_ready`=0 is ignored; the source holds it.
- States and transitions:
  - INIT_CLR: fills every cell 0..COLS*ROWS-1 with 0x20, then goes to IDLE.
  - IDLE: `char_ready`=1 and bytes are accepted.
  - LINE_CLR: fills the COLS cells of the cursor row with 0x20, then goes to IDLE.
- Printable byte (any byte not listed below): written at the cursor, then col+1.
  - At col=COLS-1: col←0, row←row+1 wrapping ROWS-1→0, then LINE_CLR on the new row.
- 0x0A LF: col←0, row+1 with wrap, then LINE_CLR. No character write.
- 0x0D CR: col←0. No write.
- 0x08 BS: if col>0, col←col-1 and 0x20 is written at the new position. At col=0 it is a no-op; no reverse row wrap.
- 0x0C FF: cursor←0/0, then INIT_CLR (full clear).
- Address is maintained incrementally (+1, +COLS, reset to row base); no multiplier.
- Cursor outputs reflect an accepted byte's effect from the cycle after acceptance.
- `reset_n` low mid-fill aborts the fill. On release the block restarts INIT_CLR from address 0.

## Timing
- Byte accepted at edge k:
  - Character write: `wr_en` high during cycle k+1 only, with the old cursor address.
  - Throughput: printable bytes that do not wrap sustain 1 byte/cycle.
- LF accepted at edge k:
  - `char_ready` is 0 from cycle k+1.
  - Clear writes occupy cycles k+1..k+COLS.
  - `char_ready` is 1 again in cycle k+COLS+1.
- Printable byte at col COLS-1:
  - Character write in cycle k+1.
  - Clear writes in cycles k+2..k+COLS+1.
  - Ready again in cycle k+COLS+2.
- INIT_CLR after reset release:
  - Writes occur in the COLS*ROWS cycles following the first rising edge.
  - `char_ready` rises in the next cycle.
- FF: same as INIT_CLR, counted from the acceptance edge.
- `busy` = state≠IDLE, registered, aligned with `char_ready` inverted.

## Configuration
- `VGA_TEXT_WRITER_TAB_EN` defined: 0x09 advances col to the next multiple of 8.
  - No cells are written.
  - If the result is ≥COLS, 0x09 behaves exactly as LF.
- Not defined: 0x09 is an ordinary printable byte.

## Structure
- Package `vga_text_pkg` holds:
  - COLS/ROWS defaults.
  - Control-code constants (LF, CR, BS, FF, TAB, SPACE=0x20).
  - State enum `writer_state_t`.
- One sub-module, `vga_text_fill`: a start/len/done sequential address generator shared by INIT_CLR and LINE_CLR.

## Test plan
- Reset release, no input:
  - 2400 writes of 0x20 to addresses 0..2399.
  - `char_ready` rises in cycle 2401 and `busy` falls.
- "AB" back-to-back from IDLE at 0/0:
  - Writes (0,0x41) then (1,0x42) on consecutive cycles.
  - `cursor_col`=2.
- Cursor at col 79, row 29; byte 0x43:
  - Write (2399,0x43), then 80 writes of 0x20 at 0..79.
  - Cursor 0/0; `char_ready` low 81 cycles.
- Cursor col 5, row 3; 0x08:
  - Write (244,0x20); `cursor_col`=4.
  - Then 0x0D → col 0, no write; 0x08 at col 0 → no write.
- 0x0C mid-screen, with reset asserted after 1000 of the clear writes:
  - After release, the clear restarts at address 0 and cursor is 0/0.
- With `VGA_TEXT_WRITER_TAB_EN` and col 3: 0x09 → col 8, no write.
  - Col 77: 0x09 behaves as LF.
  - Without the macro: 0x09 → write (addr,0x09).
